// File: rtl/zsdram_scheduler.sv
// SDRAM task scheduler: one-shot init, periodic auto-refresh and
// round-robin write/read arbitration in front of the command engine.
module zsdram_scheduler #(
    parameter int ADDR_W     = 24,
    parameter int REF_PERIOD = 780,
    parameter int TIMEOUT    = 1023,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              task_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              init_start,
    output logic              ref_start,
    output logic              wr_start,
    output logic              rd_start,
    output logic [ADDR_W-1:0] sys_addr,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              wr_done,
    output logic              rd_done,
    output logic              ready,
    output logic              busy,
    output logic              ref_overrun,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_INIT_GO,
        S_INIT_WAIT,
        S_IDLE,
        S_REF,
        S_WR,
        S_RD
    } state_t;

    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_PERIOD - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  ref_cnt_q;
    logic [CNT_W-1:0]  ref_cnt_d;
    logic [CNT_W-1:0]  to_cnt_q;
    logic              ref_pend_q;
    logic              ref_pend_d;
    logic              ref_ovr_q;
    logic              ref_ovr_d;
    logic              last_gnt_q;
    logic              init_start_q;
    logic              ref_start_q;
    logic              wr_start_q;
    logic              rd_start_q;
    logic              wr_done_q;
    logic              rd_done_q;
    logic              ready_q;
    logic              busy_q;
    logic              err_to_q;
    logic [ADDR_W-1:0] sys_addr_q;

    logic ref_tick;
    logic in_idle;
    logic gnt_ref;
    logic gnt_wr;
    logic gnt_rd;
    logic to_hit;

    always_comb begin
        ref_tick = ready_q && (ref_cnt_q == REF_LAST);
        in_idle  = (state_q == S_IDLE);
        gnt_ref  = in_idle && ref_pend_q;
        // last_gnt_q = 1 means read went last, so write wins a tie
        gnt_rd   = in_idle && !ref_pend_q && ready_q && rd_req
                   && (!wr_req || !last_gnt_q);
        gnt_wr   = in_idle && !ref_pend_q && ready_q && wr_req && !gnt_rd;
        to_hit   = (to_cnt_q == TO_LAST);
    end

    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        ref_ovr_d  = ref_ovr_q;
        if (ready_q) begin
            ref_cnt_d = ref_tick ? '0 : ref_cnt_q + 1'b1;
        end
        // a tick on the grant edge re-arms the request it just served
        if (ref_tick) begin
            ref_pend_d = 1'b1;
            if (ref_pend_q) begin
                ref_ovr_d = 1'b1;
            end
        end else if (gnt_ref) begin
            ref_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_INIT_GO;
            ref_cnt_q    <= '0;
            to_cnt_q     <= '0;
            ref_pend_q   <= 1'b0;
            ref_ovr_q    <= 1'b0;
            last_gnt_q   <= 1'b1;
            init_start_q <= 1'b0;
            ref_start_q  <= 1'b0;
            wr_start_q   <= 1'b0;
            rd_start_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            rd_done_q    <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            err_to_q     <= 1'b0;
            sys_addr_q   <= '0;
        end else begin
            ref_cnt_q    <= ref_cnt_d;
            ref_pend_q   <= ref_pend_d;
            ref_ovr_q    <= ref_ovr_d;
            init_start_q <= 1'b0;
            ref_start_q  <= 1'b0;
            wr_start_q   <= 1'b0;
            rd_start_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            rd_done_q    <= 1'b0;
            unique case (state_q)
                S_INIT_GO: begin
                    init_start_q <= 1'b1;
                    busy_q       <= 1'b1;
                    state_q      <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (init_done) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (gnt_ref) begin
                        ref_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= S_REF;
                    end else if (gnt_wr) begin
                        wr_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        to_cnt_q   <= '0;
                        last_gnt_q <= 1'b0;
                        sys_addr_q <= wr_addr;
                        state_q    <= S_WR;
                    end else if (gnt_rd) begin
                        rd_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        to_cnt_q   <= '0;
                        last_gnt_q <= 1'b1;
                        sys_addr_q <= rd_addr;
                        state_q    <= S_RD;
                    end
                end
                S_REF, S_WR, S_RD: begin
                    if (task_done) begin
                        wr_done_q <= (state_q == S_WR);
                        rd_done_q <= (state_q == S_RD);
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (to_hit) begin
                        err_to_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b1;
                    state_q <= S_INIT_GO;
                end
            endcase
        end
    end

    assign init_start  = init_start_q;
    assign ref_start   = ref_start_q;
    assign wr_start    = wr_start_q;
    assign rd_start    = rd_start_q;
    assign wr_ack      = wr_start_q;
    assign rd_ack      = rd_start_q;
    assign wr_done     = wr_done_q;
    assign rd_done     = rd_done_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign ref_overrun = ref_ovr_q;
    assign err_timeout = err_to_q;
    assign sys_addr    = sys_addr_q;

endmodule

// File: tb/tb_zsdram_scheduler.sv
// Bench for zsdram_scheduler: directed vector table, corner-case sequences
// and randomized traffic checked every cycle against a reference model.
module tb_zsdram_scheduler;

    localparam int AW = 24;
    localparam int P  = 20;
    localparam int TO = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, init_done, task_done, wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          init_start, ref_start, wr_start, rd_start;
    logic          wr_ack, rd_ack, wr_done, rd_done;
    logic          ready, busy, ref_overrun, err_timeout;
    logic [AW-1:0] sys_addr;

    int checks = 0;
    int errors = 0;

    zsdram_scheduler #(
        .ADDR_W(AW), .REF_PERIOD(P), .TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .task_done(task_done), .wr_req(wr_req), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_addr(rd_addr), .init_start(init_start),
        .ref_start(ref_start), .wr_start(wr_start), .rd_start(rd_start),
        .sys_addr(sys_addr), .wr_ack(wr_ack), .rd_ack(rd_ack),
        .wr_done(wr_done), .rd_done(rd_done), .ready(ready), .busy(busy),
        .ref_overrun(ref_overrun), .err_timeout(err_timeout)
    );

    wire [7:0] act_strb = {init_start, ref_start, wr_start, rd_start,
                           wr_ack, rd_ack, wr_done, rd_done};
    wire [3:0] act_flag = {ready, busy, ref_overrun, err_timeout};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the scheduler as phases and tasks, refresh
    // ticks derived from how many ready cycles have elapsed.
    bit          m_valid = 0;
    int          m_stage, m_kind, m_age, m_rcyc;
    bit          m_owed, m_lastrd;
    bit          e_init, e_ref, e_wr, e_rd, e_wack, e_rack, e_wdone, e_rdone;
    bit          e_ready, e_busy, e_ovr, e_to;
    logic [23:0] e_addr;

    always @(posedge clk) begin : ref_model
        bit tick, owed0, refgo, pick_rd;
        {e_init, e_ref, e_wr, e_rd, e_wack, e_rack, e_wdone, e_rdone} = 8'b0;
        m_valid = 1;
        if (!rst_n) begin
            m_stage = 0; m_kind = 0; m_age = 0; m_rcyc = 0;
            m_owed = 0; m_lastrd = 1;
            e_ready = 0; e_busy = 1; e_ovr = 0; e_to = 0; e_addr = '0;
        end else begin
            tick = 0; refgo = 0; owed0 = m_owed;
            if (e_ready) begin
                tick = (m_rcyc % P) == P - 1;
                m_rcyc++;
            end
            if (m_stage == 0) begin
                e_init = 1; e_busy = 1; m_stage = 1;
            end else if (m_stage == 1) begin
                if (init_done) begin
                    e_ready = 1; e_busy = 0; m_stage = 2;
                end
            end else if (m_kind == 0) begin
                if (owed0) begin
                    m_kind = 1; refgo = 1; e_ref = 1; e_busy = 1; m_age = 0;
                end else if (wr_req || rd_req) begin
                    pick_rd = rd_req && (!wr_req || !m_lastrd);
                    m_lastrd = pick_rd;
                    m_age = 0; e_busy = 1;
                    if (pick_rd) begin
                        m_kind = 3; e_rd = 1; e_rack = 1; e_addr = rd_addr;
                    end else begin
                        m_kind = 2; e_wr = 1; e_wack = 1; e_addr = wr_addr;
                    end
                end
            end else if (task_done) begin
                e_wdone = (m_kind == 2);
                e_rdone = (m_kind == 3);
                m_kind = 0; e_busy = 0;
            end else if (m_age == TO - 1) begin
                e_to = 1; m_kind = 0; e_busy = 0;
            end else begin
                m_age++;
            end
            if (tick) begin
                if (owed0) e_ovr = 1;
                m_owed = 1;
            end else if (refgo) begin
                m_owed = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({act_strb, act_flag, sys_addr} !==
                {e_init, e_ref, e_wr, e_rd, e_wack, e_rack, e_wdone, e_rdone,
                 e_ready, e_busy, e_ovr, e_to, e_addr}) begin
                errors++;
                $display("FAIL model t=%0t: got strb=%b flag=%b addr=%h expected strb=%b flag=%b addr=%h",
                         $time, act_strb, act_flag, sys_addr,
                         {e_init, e_ref, e_wr, e_rd, e_wack, e_rack, e_wdone, e_rdone},
                         {e_ready, e_busy, e_ovr, e_to}, e_addr);
            end
        end
    end

    typedef struct {
        logic        r, id, td, wq, rq;
        logic [23:0] wa, ra;
        logic [7:0]  es;
        logic [3:0]  ef;
        logic [23:0] ea;
    } vec_t;
    vec_t vec[$];

    task automatic add(input logic r, id, td, wq, rq,
                       input logic [23:0] wa, ra,
                       input logic [7:0] es, input logic [3:0] ef,
                       input logic [23:0] ea);
        vec_t v;
        v = '{r, id, td, wq, rq, wa, ra, es, ef, ea};
        vec.push_back(v);
    endtask

    bit auto_eng, cont_wr, rnd_req;
    int fix_lat, eng_cnt, init_cnt;

    task automatic step();
        int lat;
        @(posedge clk);
        #1;
        init_done = 0;
        task_done = 0;
        if (!rst_n) begin
            eng_cnt = 0;
            init_cnt = 0;
        end
        if (auto_eng) begin
            if (init_start) init_cnt = $urandom_range(1, 6);
            if (init_cnt > 0) begin
                init_cnt--;
                if (init_cnt == 0) init_done = 1;
            end
            if (ref_start || wr_start || rd_start) begin
                lat = (fix_lat != 0) ? fix_lat : $urandom_range(1, 5);
                if (rnd_req && $urandom_range(0, 29) == 0) lat = 0;
                eng_cnt = lat;
            end
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) task_done = 1;
            end
        end
        if (cont_wr) begin
            wr_req = 1;
            if (wr_ack) wr_addr = 24'($urandom);
        end
        if (rnd_req) begin
            if (wr_ack) begin
                wr_req = 1'($urandom_range(0, 1));
                wr_addr = 24'($urandom);
            end else if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1; wr_addr = 24'($urandom);
            end
            if (rd_ack) begin
                rd_req = 1'($urandom_range(0, 1));
                rd_addr = 24'($urandom);
            end else if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1; rd_addr = 24'($urandom);
            end
            if ($urandom_range(0, 40) == 0) task_done = 1;
            if ($urandom_range(0, 40) == 0) init_done = 1;
            rst_n = ($urandom_range(0, 799) != 0);
            if (!rst_n) begin
                wr_req = 0; rd_req = 0;
            end
        end
    endtask

    localparam logic [23:0] A = 24'h12_3456;
    localparam logic [23:0] B = 24'hC0_FFEE;
    localparam logic [23:0] W = 24'h40_1234;

    initial begin
        int n, nref, nwr, ngnt;
        bit saw_wd;
        rst_n = 0; init_done = 0; task_done = 0;
        wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0;
        auto_eng = 0; cont_wr = 0; rnd_req = 0;
        fix_lat = 0; eng_cnt = 0; init_cnt = 0;

        add(0,0,0,0,0, 0,0, 8'h00, 4'b0100, 0);
        add(0,0,0,0,0, 0,0, 8'h00, 4'b0100, 0);
        add(1,0,0,0,0, 0,0, 8'h80, 4'b0100, 0);
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, 0,0, 8'h00, 4'b0100, 0);
        add(1,1,0,0,0, 0,0, 8'h00, 4'b1000, 0);
        add(1,0,0,1,1, A,B, 8'h28, 4'b1100, A);
        add(1,0,1,1,1, A,B, 8'h02, 4'b1000, A);
        add(1,0,0,1,1, A,B, 8'h14, 4'b1100, B);
        add(1,0,1,1,1, A,B, 8'h01, 4'b1000, B);
        add(1,0,0,1,1, A,B, 8'h28, 4'b1100, A);
        add(1,0,1,1,1, A,B, 8'h02, 4'b1000, A);
        add(1,0,0,1,1, A,B, 8'h14, 4'b1100, B);
        add(1,0,1,0,0, A,B, 8'h01, 4'b1000, B);
        add(1,0,0,1,0, W,B, 8'h28, 4'b1100, W);
        add(1,0,0,0,0, W,B, 8'h00, 4'b1100, W);
        add(1,0,1,0,0, W,B, 8'h02, 4'b1000, W);
        add(1,0,0,0,0, W,B, 8'h00, 4'b1000, W);
        add(1,0,1,0,0, W,B, 8'h00, 4'b1000, W);
        add(1,1,0,0,0, W,B, 8'h00, 4'b1000, W);

        foreach (vec[i]) begin
            rst_n = vec[i].r; init_done = vec[i].id; task_done = vec[i].td;
            wr_req = vec[i].wq; rd_req = vec[i].rq;
            wr_addr = vec[i].wa; rd_addr = vec[i].ra;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_strb", i), act_strb, vec[i].es);
            chk($sformatf("vec%0d_flag", i), act_flag, vec[i].ef);
            chk($sformatf("vec%0d_addr", i), sys_addr, vec[i].ea);
        end
        init_done = 0; task_done = 0; wr_req = 0; rd_req = 0;

        // refresh under continuous write traffic
        auto_eng = 1; cont_wr = 1; fix_lat = 2;
        nref = 0; nwr = 0;
        repeat (400) begin
            step();
            if (ref_start) nref++;
            if (wr_start) nwr++;
        end
        chk("t4_ref_count", (nref >= 19 && nref <= 21), 1);
        chk("t4_wr_traffic", (nwr >= 60), 1);
        chk("t4_no_overrun", ref_overrun, 0);
        chk("t4_no_timeout", err_timeout, 0);

        // stuck write: timeout and refresh overrun
        cont_wr = 0;
        n = 0;
        do begin step(); n++; end while (!wr_ack && n < 60);
        chk("t5_wr_grant", wr_ack, 1);
        eng_cnt = 0; task_done = 0; wr_req = 0;
        n = 0; saw_wd = 0;
        do begin
            step(); n++;
            if (wr_done) saw_wd = 1;
        end while (!err_timeout && n < 300);
        chk("t5_to_latency", n, TO);
        chk("t5_no_wr_done", saw_wd, 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_overrun", ref_overrun, 1);
        step();
        chk("t5_ref_after", ref_start, 1);

        // reset in the middle of a read
        n = 0;
        do begin step(); n++; end while (busy && n < 50);
        rd_req = 1; rd_addr = 24'h5A_A5A5;
        n = 0;
        do begin step(); n++; end while (!rd_ack && n < 60);
        chk("t6_rd_grant", rd_ack, 1);
        eng_cnt = 0; task_done = 0; rd_req = 0;
        step();
        chk("t6_in_rd_busy", busy, 1);
        rst_n = 0;
        step();
        chk("t6_rst_strb", act_strb, 8'h00);
        chk("t6_rst_flag", act_flag, 4'b0100);
        chk("t6_rst_addr", sys_addr, 24'h0);
        step();
        rst_n = 1;
        step();
        chk("t6_init_again", init_start, 1);
        n = 0;
        do begin step(); n++; end while (!ready && n < 20);
        chk("t6_ready_again", ready, 1);

        // randomized traffic, engine latency, noise and sporadic resets
        fix_lat = 0; rnd_req = 1; ngnt = 0;
        repeat (4000) begin
            step();
            if (wr_start || rd_start) ngnt++;
        end
        chk("rand_activity", (ngnt > 50), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
